// File: rtl/io_port.sv
// Byte-wide CPU I/O responder: output FIFO (addr 0), input FIFO (addr 1), status (addr 2).
// Define IO_PORT_TRACE_EN to print one line per access event and on overflow/underflow.
module io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  inout  wire  [7:0] bus,
  input  logic       mem_clk,
  input  logic       mem_io,
  input  logic       c_ri,
  input  logic       c_ro,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [7:0] ADDR_TX   = 8'h00;
  localparam logic [7:0] ADDR_RX   = 8'h01;
  localparam logic [7:0] ADDR_STAT = 8'h02;

  logic          s;
  logic          s_q, s_d;
  logic          evt;
  logic          is_rd, is_wr;
  logic          sel_tx, sel_rx, sel_stat;

  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];

  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push_req, tx_push, tx_drop, tx_pop;
  logic          rx_pop_req, rx_pop, rx_under, rx_push;
  logic          flag_clr;

  logic [7:0]    status;
  logic [7:0]    rx_head;
  logic [7:0]    rd_data;
  logic          bus_oe;

  always_comb begin
    s     = mem_io & mem_clk & (c_ri | c_ro);
    s_d   = s;
    evt   = s & ~s_q;
    // Simultaneous read and write strobes resolve to a read.
    is_rd = c_ro;
    is_wr = c_ri & ~c_ro;

    sel_tx   = (addr_bus == ADDR_TX);
    sel_rx   = (addr_bus == ADDR_RX);
    sel_stat = (addr_bus == ADDR_STAT);
  end

  always_comb begin
    tx_empty = (tx_wp_q == tx_rp_q);
    tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
               (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    rx_empty = (rx_wp_q == rx_rp_q);
    rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
               (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

    tx_valid = ~tx_empty;
    tx_data  = tx_mem_q[tx_rp_q[AW-1:0]];
    rx_ready = ~rx_full;
    rx_head  = rx_mem_q[rx_rp_q[AW-1:0]];
  end

  // Fullness is judged on registered pointers, so a same-cycle sink pop
  // cannot make room for a CPU push into a full output FIFO.
  always_comb begin
    tx_push_req = evt & is_wr & sel_tx;
    tx_push     = tx_push_req & ~tx_full;
    tx_drop     = tx_push_req & tx_full;
    tx_pop      = tx_valid & tx_ready;

    rx_push     = rx_valid & rx_ready;
    rx_pop_req  = evt & is_rd & sel_rx;
    rx_pop      = rx_pop_req & ~rx_empty;
    rx_under    = rx_pop_req & rx_empty;

    flag_clr    = evt & is_wr & sel_stat;
  end

  always_comb begin
    tx_wp_d = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + PW'(1) : tx_rp_q;
    rx_wp_d = rx_push ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + PW'(1) : rx_rp_q;

    // Setting a sticky flag takes priority over clearing it.
    tx_ovf_d = tx_drop  | (tx_ovf_q & ~flag_clr);
    rx_ovf_d = rx_under | (rx_ovf_q & ~flag_clr);
  end

  always_comb begin
    status  = {3'b000, rx_ovf_q, tx_ovf_q, ~rx_empty, tx_full, tx_empty};
    rd_data = 8'h00;
    if (sel_rx) begin
      rd_data = rx_empty ? 8'hFF : rx_head;
    end else if (sel_stat) begin
      rd_data = status;
    end
    bus_oe = s & is_rd & (sel_rx | sel_stat);
  end

  assign bus = bus_oe ? rd_data : 8'hZZ;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      // Tracking the live strobe through reset keeps a strobe that spans
      // reset release from being seen as a fresh access.
      s_q      <= s_d;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      s_q      <= s_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wp_q[AW-1:0]] <= bus;
    end
    if (rx_push) begin
      rx_mem_q[rx_wp_q[AW-1:0]] <= rx_data;
    end
  end

`ifdef IO_PORT_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && evt) begin
      if (sel_tx) begin
        $display("Output: %d ($%h)", bus, bus);
      end else if (sel_rx) begin
        $display("Input: %d ($%h)", rd_data, rd_data);
      end else begin
        $display("Unknown I/O on address $%h: %d ($%h)", addr_bus, bus, bus);
      end
    end
    if (!reset && ((tx_ovf_d & ~tx_ovf_q) | (rx_ovf_d & ~rx_ovf_q))) begin
      $display("I/O overflow");
    end
  end
`else
  // Silent build: datapath and control are identical to the traced build.
`endif

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: cycle-level vector table plus hand-written corner sequences.
module tb_io_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr_bus;
  logic       mem_clk, mem_io, c_ri, c_ro;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] bus;

  assign bus = tb_drv ? tb_val : 8'hzz;

  io_port #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .bus(bus),
    .mem_clk(mem_clk), .mem_io(mem_io), .c_ri(c_ri), .c_ro(c_ro),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       s;
    logic       rd;
    logic [7:0] a;
    logic [7:0] d;
    logic       txr;
    logic       rxv;
    logic [7:0] rxd;
    int         bchk;   // 0 none, 1 compare value, 2 expect undriven
    logic [7:0] ebus;
    logic       etxv;
    logic [7:0] etxd;
    logic       erxr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic rd, input logic [7:0] a,
                              input logic [7:0] d, input logic txr, input logic rxv,
                              input logic [7:0] rxd, input int bchk, input logic [7:0] ebus,
                              input logic etxv, input logic [7:0] etxd, input logic erxr);
    vec_t v;
    v.s = s; v.rd = rd; v.a = a; v.d = d; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.bchk = bchk; v.ebus = ebus; v.etxv = etxv; v.etxd = etxd; v.erxr = erxr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A two-state simulator resolves an undriven bus to zero.
  task automatic chk_float(input string name);
    checks++;
    if (!((bus === 8'hzz) || (bus === 8'h00))) begin
      errors++;
      $display("FAIL %s: bus driven with %h expected undriven", name, bus);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic s, input logic rd, input logic [7:0] a, input logic [7:0] d);
    mem_io   = s;
    mem_clk  = s;
    c_ro     = s & rd;
    c_ri     = s & ~rd;
    addr_bus = a;
    tb_drv   = s & ~rd;
    tb_val   = d;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    set_bus(1'b1, 1'b0, a, d);
    tick();
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [7:0] v);
    set_bus(1'b1, 1'b1, a, 8'h00);
    #1;
    v = bus;
    tick();
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic chk_status(input string name, input logic [7:0] exp);
    logic [7:0] v;
    cpu_rd(8'h02, v);
    chk(name, v, exp);
  endtask

  task automatic chk_tx(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {7'd0, tx_valid}, 8'h01);
    chk({name, "_data"}, tx_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;

    reset = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk_float("rst_bus");
    chk_status("rst_status", 8'h01);

    //        s  rd  a      d      txr rxv rxd    bchk ebus   etxv etxd   erxr
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 0, 8'h00, 8'h2A, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 8'h2A, 1));
    tbl.push_back(mk(1, 0, 8'h00, 8'h07, 0, 0, 8'h00, 0, 8'h00, 1, 8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 8'h2A, 1));
    tbl.push_back(mk(1, 1, 8'h02, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h07, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h02, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 8'h5C, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h01, 8'h00, 0, 0, 8'h00, 1, 8'h5C, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h01, 8'h00, 0, 0, 8'h00, 1, 8'hFF, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h02, 8'h00, 0, 0, 8'h00, 1, 8'h11, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h02, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 2, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h03, 8'h00, 0, 0, 8'h00, 2, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 0, 8'h01, 8'h55, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 8'h02, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2, 8'h00, 0, 8'h00, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      set_bus(tbl[i].s, tbl[i].rd, tbl[i].a, tbl[i].d);
      tx_ready = tbl[i].txr;
      rx_valid = tbl[i].rxv;
      rx_data  = tbl[i].rxd;
      #1;
      if (tbl[i].bchk == 1) chk($sformatf("vec%0d_bus", i), bus, tbl[i].ebus);
      if (tbl[i].bchk == 2) chk_float($sformatf("vec%0d_float", i));
      chk($sformatf("vec%0d_tx_valid", i), {7'd0, tx_valid}, {7'd0, tbl[i].etxv});
      if (tbl[i].etxv) chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].etxd);
      chk($sformatf("vec%0d_rx_ready", i), {7'd0, rx_ready}, {7'd0, tbl[i].erxr});
      tick();
    end
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tx_ready = 1'b0; rx_valid = 1'b0;
    tick();

    // Overflow on a full output FIFO, then drain and clear.
    for (int i = 1; i <= 5; i++) cpu_wr(8'h00, 8'(i));
    chk_status("ovf_status", 8'h0A);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_tx($sformatf("ovf_drain%0d", k), 8'(k + 1));
      tick();
    end
    tx_ready = 1'b0;
    chk("ovf_empty", {7'd0, tx_valid}, 8'h00);
    cpu_wr(8'h02, 8'h99);
    chk_status("ovf_cleared", 8'h01);

    // A strobe held for several cycles produces a single push.
    set_bus(1'b1, 1'b0, 8'h00, 8'hAA);
    repeat (5) tick();
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk_status("hold_status", 8'h00);
    chk_tx("hold_head", 8'hAA);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("hold_one_entry", {7'd0, tx_valid}, 8'h00);

    // Same-cycle push and pop with two entries queued.
    cpu_wr(8'h00, 8'h11);
    cpu_wr(8'h00, 8'h22);
    tx_ready = 1'b1;
    set_bus(1'b1, 1'b0, 8'h00, 8'h33);
    #1;
    chk_tx("pp_head", 8'h11);
    tick();
    tx_ready = 1'b0;
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk_status("pp_status", 8'h00);
    tx_ready = 1'b1;
    chk_tx("pp_drain0", 8'h22);
    tick();
    chk_tx("pp_drain1", 8'h33);
    tick();
    tx_ready = 1'b0;
    chk("pp_empty", {7'd0, tx_valid}, 8'h00);

    // Same-cycle push and pop on a full FIFO: the push is dropped.
    for (int i = 0; i < 4; i++) cpu_wr(8'h00, 8'(8'h41 + i));
    chk_status("fp_full", 8'h02);
    tx_ready = 1'b1;
    set_bus(1'b1, 1'b0, 8'h00, 8'h45);
    #1;
    chk_tx("fp_head", 8'h41);
    tick();
    tx_ready = 1'b0;
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk_status("fp_status", 8'h08);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_tx($sformatf("fp_drain%0d", k), 8'(8'h42 + k));
      tick();
    end
    tx_ready = 1'b0;
    chk("fp_empty", {7'd0, tx_valid}, 8'h00);
    cpu_wr(8'h02, 8'h00);
    chk_status("fp_cleared", 8'h01);

    // Reset with both FIFOs holding data and a strobe spanning release.
    for (int i = 0; i < 3; i++) cpu_wr(8'h00, 8'(8'h61 + i));
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'(8'h71 + i);
      tick();
    end
    rx_valid = 1'b0;
    chk_status("rst2_pre", 8'h04);
    set_bus(1'b1, 1'b0, 8'h00, 8'h77);
    reset = 1'b1;
    tick();
    tick();
    chk("rst2_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst2_rx_ready", {7'd0, rx_ready}, 8'h01);
    reset = 1'b0;
    tick();
    tick();
    set_bus(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk_float("rst2_bus");
    tick();
    chk("rst2_no_event", {7'd0, tx_valid}, 8'h00);
    chk_status("rst2_status", 8'h01);
    cpu_rd(8'h01, v);
    chk("rst2_rx_empty", v, 8'hFF);
    chk_status("rst2_underflow", 8'h11);
    cpu_wr(8'h00, 8'h5A);
    chk_tx("rst2_new_strobe", 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
